// File: rtl/red_pitaya_trigseq_pkg.sv
// Shared definitions for the trigger sequencer: FSM state encoding, register
// offsets and the upper bound on requester count.
// Optional feature macro: TRIG_SEQ_TIMEOUT_EN adds the TOUT state.
package red_pitaya_trigseq_pkg;

  localparam int unsigned NREQ_MAX = 8;

  // Encoding is software-visible through status[2:0].
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArm   = 3'd1,
    StWait  = 3'd2,
    StDelay = 3'd3,
    StFire  = 3'd4,
    StHold  = 3'd5
`ifdef TRIG_SEQ_TIMEOUT_EN
    ,
    StTout  = 3'd6
`endif
  } state_e;

  localparam logic [15:0] AddrCtrl    = 16'h0000;
  localparam logic [15:0] AddrDelay   = 16'h0004;
  localparam logic [15:0] AddrHoldoff = 16'h0008;
  localparam logic [15:0] AddrMask    = 16'h000C;
  localparam logic [15:0] AddrStatus  = 16'h0010;
  localparam logic [15:0] AddrTsLo    = 16'h0014;
  localparam logic [15:0] AddrTsHi    = 16'h0018;
  localparam logic [15:0] AddrEvCnt   = 16'h001C;
  localparam logic [15:0] AddrTimeout = 16'h0020;

endpackage

// File: rtl/red_pitaya_trigger_sequencer_if.sv
// PS register bus bundle for the trigger sequencer.
//   addr  : 16-bit register address
//   wen   : write strobe, wdata : write data
//   ren   : read strobe,  rdata : read data
//   ack   : acknowledge, one cycle after wen|ren
// master: bus initiator (PS side); slave: the sequencer.
interface red_pitaya_trigger_sequencer_if;
  logic [15:0] addr;
  logic        wen;
  logic        ren;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output addr, wen, ren, wdata, input ack, rdata);
  modport slave  (input addr, wen, ren, wdata, output ack, rdata);
endinterface

// File: rtl/red_pitaya_rr_arbiter.sv
// Combinational round-robin pick.
//   pend_i  : pending request vector
//   last_i  : index of the previously granted requester
//   grant_o : first set bit of pend_i searching upward from last_i+1 (mod NREQ)
//   valid_o : at least one request pending
module red_pitaya_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned GW   = 3
) (
  input  logic [NREQ-1:0] pend_i,
  input  logic [GW-1:0]   last_i,
  output logic [GW-1:0]   grant_o,
  output logic            valid_o
);

  int unsigned idx;

  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = 0;
    // Offsets 1..NREQ so last_i itself is considered last.
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(last_i) + i) % NREQ;
      if (!valid_o && ((pend_i & (NREQ'(1) << idx)) != '0)) begin
        valid_o = 1'b1;
        grant_o = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/red_pitaya_trigger_sequencer.sv
// Round-robin trigger sequencer: shares one trigger block among NREQ requesters.
// Grants a pending requester, pulses arm_o, waits for trig_i, applies a delay,
// routes a one-cycle trigger to the granted requester, then holds off.
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i        : level requests, trig_i : trigger pulse from the trigger block
//   arm_o        : rearm pulse, trig_o : routed trigger (one-hot), busy_o : not idle
//   bus          : PS register bus (slave modport)
// Optional feature macro: TRIG_SEQ_TIMEOUT_EN (WAIT watchdog, TOUT state,
// timeout register at 0x20, sticky status[17]).
module red_pitaya_trigger_sequencer
  import red_pitaya_trigseq_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned GW   = 3,
  parameter int unsigned CW   = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NREQ-1:0]                req_i,
  input  logic                           trig_i,
  output logic                           arm_o,
  output logic [NREQ-1:0]                trig_o,
  output logic                           busy_o,
  red_pitaya_trigger_sequencer_if.slave  bus
);

  state_e          state_q;
  logic [GW-1:0]   grant_q, last_q, arb_grant;
  logic            arb_valid;
  logic [NREQ-1:0] pend, trig_q, mask_q;
  logic            arm_q, enable_q;
  logic [CW-1:0]   delay_q, holdoff_q, dcnt_q, hcnt_q;
  logic [63:0]     cnt_q, ts_q;
  logic [31:0]     ev_cnt_q;
  logic            ack_q;
  logic [31:0]     rdata_q, rd_data, status;
  logic            ctrl_wr, kill, req_granted;
`ifdef TRIG_SEQ_TIMEOUT_EN
  logic [CW-1:0]   timeout_q, tcnt_q;
  logic            flag_q, flag_clr;
`endif

  assign pend        = req_i & mask_q;
  assign req_granted = (req_i & (NREQ'(1) << grant_q)) != '0;
  assign ctrl_wr     = bus.wen && (bus.addr == AddrCtrl);
  // Abort, clearing enable, or already disabled all force IDLE.
  assign kill        = !enable_q || (ctrl_wr && (bus.wdata[1] || !bus.wdata[0]));
`ifdef TRIG_SEQ_TIMEOUT_EN
  assign flag_clr    = bus.wen && (bus.addr == AddrStatus) && bus.wdata[17];
`endif

  red_pitaya_rr_arbiter #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_arb (
    .pend_i  (pend),
    .last_i  (last_q),
    .grant_o (arb_grant),
    .valid_o (arb_valid)
  );

  always_comb begin
    status        = '0;
    status[2:0]   = state_q;
    status[10:8]  = 3'(grant_q);
    status[16]    = (state_q != StIdle);
`ifdef TRIG_SEQ_TIMEOUT_EN
    status[17]    = flag_q;
`endif
  end

  always_comb begin
    rd_data = '0;
    case (bus.addr)
      AddrCtrl:    rd_data = {31'b0, enable_q};
      AddrDelay:   rd_data = 32'(delay_q);
      AddrHoldoff: rd_data = 32'(holdoff_q);
      AddrMask:    rd_data = 32'(mask_q);
      AddrStatus:  rd_data = status;
      AddrTsLo:    rd_data = ts_q[31:0];
      AddrTsHi:    rd_data = ts_q[63:32];
      AddrEvCnt:   rd_data = ev_cnt_q;
`ifdef TRIG_SEQ_TIMEOUT_EN
      AddrTimeout: rd_data = 32'(timeout_q);
`endif
      default:     rd_data = '0;
    endcase
  end

  // Configuration registers and bus response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable_q  <= 1'b0;
      delay_q   <= '0;
      holdoff_q <= '0;
      mask_q    <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
`ifdef TRIG_SEQ_TIMEOUT_EN
      timeout_q <= '0;
`endif
    end else begin
      ack_q   <= bus.wen | bus.ren;
      rdata_q <= bus.ren ? rd_data : '0;
      if (bus.wen) begin
        case (bus.addr)
          AddrCtrl:    enable_q  <= bus.wdata[0];
          AddrDelay:   delay_q   <= CW'(bus.wdata);
          AddrHoldoff: holdoff_q <= CW'(bus.wdata);
          AddrMask:    mask_q    <= NREQ'(bus.wdata);
`ifdef TRIG_SEQ_TIMEOUT_EN
          AddrTimeout: timeout_q <= CW'(bus.wdata);
`endif
          default:     ;
        endcase
      end
    end
  end

  // Sequencer FSM with registered outputs. trig_o is registered from FIRE, so
  // it appears the cycle after FIRE: trig_i-to-trig_o latency is delay + 2.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      last_q   <= GW'(NREQ - 1);
      dcnt_q   <= '0;
      hcnt_q   <= '0;
      cnt_q    <= '0;
      ts_q     <= '0;
      ev_cnt_q <= '0;
      arm_q    <= 1'b0;
      trig_q   <= '0;
`ifdef TRIG_SEQ_TIMEOUT_EN
      tcnt_q   <= '0;
      flag_q   <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_q + 64'd1;
      arm_q  <= 1'b0;
      trig_q <= '0;
`ifdef TRIG_SEQ_TIMEOUT_EN
      if (flag_clr) flag_q <= 1'b0;
`endif
      if (kill) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (arb_valid) begin
              grant_q <= arb_grant;
              last_q  <= arb_grant;
              arm_q   <= 1'b1;
              state_q <= StArm;
            end
          end
          StArm: begin
`ifdef TRIG_SEQ_TIMEOUT_EN
            tcnt_q  <= '0;
`endif
            state_q <= StWait;
          end
          StWait: begin
            if (trig_i) begin
              ts_q <= cnt_q;
              if (delay_q == '0) begin
                state_q <= StFire;
              end else begin
                dcnt_q  <= delay_q;
                state_q <= StDelay;
              end
            end else if (!req_granted) begin
              state_q <= StIdle;
`ifdef TRIG_SEQ_TIMEOUT_EN
            end else if ((timeout_q != '0) && (tcnt_q + CW'(1) == timeout_q)) begin
              state_q <= StTout;
            end else begin
              tcnt_q <= tcnt_q + CW'(1);
`endif
            end
          end
`ifdef TRIG_SEQ_TIMEOUT_EN
          StTout: begin
            ts_q   <= cnt_q;
            flag_q <= 1'b1;
            if (delay_q == '0) begin
              state_q <= StFire;
            end else begin
              dcnt_q  <= delay_q;
              state_q <= StDelay;
            end
          end
`endif
          StDelay: begin
            dcnt_q <= dcnt_q - CW'(1);
            if (dcnt_q == CW'(1)) state_q <= StFire;
          end
          StFire: begin
            trig_q   <= NREQ'(1) << grant_q;
            ev_cnt_q <= ev_cnt_q + 32'd1;
            if (holdoff_q == '0) begin
              state_q <= StIdle;
            end else begin
              hcnt_q  <= holdoff_q;
              state_q <= StHold;
            end
          end
          StHold: begin
            hcnt_q <= hcnt_q - CW'(1);
            if (hcnt_q == CW'(1)) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign arm_o     = arm_q;
  assign trig_o    = trig_q;
  assign busy_o    = (state_q != StIdle);
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_red_pitaya_trigger_sequencer.sv
module tb_red_pitaya_trigger_sequencer;
  import red_pitaya_trigseq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       trig = 1'b0;
  logic       arm, busy;
  logic [3:0] trig_o;

  red_pitaya_trigger_sequencer_if bus ();

  red_pitaya_trigger_sequencer #(
    .NREQ (4),
    .GW   (3),
    .CW   (32)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_i  (req),
    .trig_i (trig),
    .arm_o  (arm),
    .trig_o (trig_o),
    .busy_o (busy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Cycle index since reset, matching the meaning of the DUT timestamp.
  longint cyc;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    logic [3:0] val;
    longint     at;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
    end
  endtask

  // Scoreboard consumer: every routed trigger must match the oldest expectation.
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (!rst && trig_o !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("unexpected trig_o", {60'b0, trig_o}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("trig_o value", {60'b0, trig_o}, {60'b0, e.val});
        check("trig_o cycle", cyc, e.at);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.wen   = 1'b1;
    step();
    bus.wen   = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
    bus.addr = a;
    bus.ren  = 1'b1;
    step();
    bus.ren  = 1'b0;
    check("bus ack", {63'b0, bus.ack}, 64'd1);
    d = bus.rdata;
  endtask

  task automatic rd_check(input string tag, input logic [15:0] a, input logic [31:0] want);
    logic [31:0] d;
    bus_rd(a, d);
    check(tag, {32'b0, d}, {32'b0, want});
  endtask

  task automatic wait_arm(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!arm && n < max);
    check("arm_o seen", {63'b0, arm}, 64'd1);
  endtask

  task automatic wait_trig(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (trig_o === 4'b0000 && n < max);
    check("trig_o seen", {63'b0, (trig_o !== 4'b0000)}, 64'd1);
  endtask

  // Called in a WAIT cycle: pulses trig_i and records the expected routed trigger.
  task automatic fire(input logic [3:0] g, input int dly, output longint ts);
    exp_t e;
    trig = 1'b1;
    ts    = cyc;
    e.val = g;
    e.at  = cyc + dly + 2;
    exp_q.push_back(e);
    step();
    trig = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n;
    longint      ts;
    logic [31:0] d;
    logic [3:0]  g;

    bus.addr  = '0;
    bus.wdata = '0;
    bus.wen   = 1'b0;
    bus.ren   = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    check("reset arm_o", {63'b0, arm}, 64'd0);
    check("reset trig_o", {60'b0, trig_o}, 64'd0);
    check("reset busy_o", {63'b0, busy}, 64'd0);
    check("reset ack", {63'b0, bus.ack}, 64'd0);
    rd_check("reset status", AddrStatus, 32'h0);
    rd_check("reset ctrl", AddrCtrl, 32'h0);
    rd_check("reset evcnt", AddrEvCnt, 32'h0);
    rd_check("reset ts_lo", AddrTsLo, 32'h0);
    rd_check("unmapped read", 16'h0040, 32'h0);

    // Round robin with all requests held: 0,1,2,3,0
    bus_wr(AddrMask, 32'hF);
    req = 4'b1111;
    bus_wr(AddrCtrl, 32'h1);
    for (int k = 0; k < 5; k++) begin
      wait_arm(10, n);
      check("arm latency", 64'(n), 64'd1);
      check("busy while armed", {63'b0, busy}, 64'd1);
      step();
      check("arm single cycle", {63'b0, arm}, 64'd0);
      g = 4'b0001 << (k % 4);
      fire(g, 0, ts);
      if (k == 4) req = 4'b0000;
      step();
    end
    rd_check("rr evcnt", AddrEvCnt, 32'd5);
    rd_check("rr ts_lo", AddrTsLo, ts[31:0]);
    rd_check("rr ts_hi", AddrTsHi, ts[63:32]);

    // Delay 10, holdoff 5, stray trigger during HOLD
    bus_wr(AddrDelay, 32'd10);
    bus_wr(AddrHoldoff, 32'd5);
    req = 4'b0100;
    wait_arm(10, n);
    check("arm latency req2", 64'(n), 64'd1);
    step();
    fire(4'b0100, 10, ts);
    wait_trig(20, n);
    check("delay latency", 64'(n), 64'd11);
    trig = 1'b1;
    step();
    trig = 1'b0;
    wait_arm(20, n);
    check("rearm after holdoff", 64'(n), 64'd5);

    // Request withdrawn in WAIT
    step();
    req = 4'b0000;
    step();
    check("withdraw busy", {63'b0, busy}, 64'd0);
    rd_check("withdraw evcnt", AddrEvCnt, 32'd6);
    rd_check("withdraw status", AddrStatus, 32'h0000_0200);

    // Abort during DELAY
    req = 4'b1000;
    wait_arm(10, n);
    step();
    trig = 1'b1;
    ts   = cyc;
    step();
    trig = 1'b0;
    repeat (3) step();
    bus_wr(AddrCtrl, 32'h3);
    req = 4'b0000;
    check("abort busy", {63'b0, busy}, 64'd0);
    repeat (15) step();
    rd_check("abort ctrl", AddrCtrl, 32'h1);
    rd_check("abort evcnt", AddrEvCnt, 32'd6);
    rd_check("abort ts kept", AddrTsLo, ts[31:0]);

    // Reset in the middle of DELAY
    req = 4'b0010;
    wait_arm(10, n);
    step();
    trig = 1'b1;
    step();
    trig = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    check("midreset arm_o", {63'b0, arm}, 64'd0);
    check("midreset trig_o", {60'b0, trig_o}, 64'd0);
    check("midreset busy_o", {63'b0, busy}, 64'd0);
    rst = 1'b0;
    req = 4'b0000;
    rd_check("midreset status", AddrStatus, 32'h0);
    rd_check("midreset evcnt", AddrEvCnt, 32'h0);
    rd_check("midreset delay", AddrDelay, 32'h0);

    // Mask selects only requester 1
    bus_wr(AddrMask, 32'h2);
    req = 4'b1111;
    bus_wr(AddrCtrl, 32'h1);
    for (int k = 0; k < 2; k++) begin
      wait_arm(10, n);
      step();
      fire(4'b0010, 0, ts);
      if (k == 1) req = 4'b0000;
      step();
    end
    rd_check("mask evcnt", AddrEvCnt, 32'd2);

`ifdef TRIG_SEQ_TIMEOUT_EN
    // Watchdog expiry with no trigger
    bus_wr(AddrHoldoff, 32'd5);
    bus_wr(AddrTimeout, 32'd100);
    bus_wr(AddrMask, 32'hF);
    req = 4'b0001;
    wait_arm(10, n);
    step();
    begin
      exp_t e;
      e.val = 4'b0001;
      e.at  = cyc + 102;
      ts    = cyc + 100;
      exp_q.push_back(e);
    end
    wait_trig(200, n);
    req = 4'b0000;
    check("timeout latency", 64'(n), 64'd102);
    bus_rd(AddrStatus, d);
    check("timeout flag set", {63'b0, d[17]}, 64'd1);
    rd_check("timeout ts_lo", AddrTsLo, ts[31:0]);
    bus_wr(AddrStatus, 32'h0002_0000);
    bus_rd(AddrStatus, d);
    check("timeout flag cleared", {63'b0, d[17]}, 64'd0);
`else
    bus_wr(AddrTimeout, 32'd123);
    rd_check("timeout reg absent", AddrTimeout, 32'h0);
`endif

    repeat (5) step();
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
